// File: rtl/rib_mem_responder_pkg.sv
// rtl/rib_mem_responder_pkg.sv - shared bus types, FSM encodings and limits for the RIB memory responder
package rib_mem_responder_pkg;

  localparam int MemBusWidth     = 32;
  localparam int MemAddrBusWidth = 32;

  typedef logic [MemBusWidth-1:0]     mem_bus_t;
  typedef logic [MemAddrBusWidth-1:0] mem_addr_bus_t;

  // Upper bound on wait states; the 4-bit countdown cannot hold more.
  localparam int RibRespWaitMax = 15;

  typedef enum logic [1:0] {
    RibRespIdle = 2'd0,
    RibRespWait = 2'd1,
    RibRespDone = 2'd2
  } rib_resp_state_e;

endpackage

// File: rtl/rib_resp_mem.sv
// rtl/rib_resp_mem.sv - word storage with one synchronous write port and two asynchronous read ports
module rib_resp_mem
  import rib_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [MemBusWidth-1:0]   wdata,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [MemBusWidth-1:0]   rd_data,
  input  logic [$clog2(DEPTH)-1:0] pc_addr,
  output logic [MemBusWidth-1:0]   pc_data
);

  mem_bus_t mem [DEPTH];

  // Contents are deliberately not reset; a write lands at the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Both reads see the pre-edge contents, so a same-cycle write returns old data.
  assign rd_data = mem[rd_addr];
  assign pc_data = mem[pc_addr];

endmodule

// File: rtl/rib_mem_responder.sv
// rtl/rib_mem_responder.sv - RIB data-port responder with wait states and fetch port; RIB_RESP_ERR_EN adds error pulse/counter
module rib_mem_responder
  import rib_mem_responder_pkg::*;
#(
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [MemAddrBusWidth-1:0] addr_i,
  input  logic [MemBusWidth-1:0]     data_i,
  output logic [MemBusWidth-1:0]     data_o,
  output logic                       hold_o,
  input  logic [MemAddrBusWidth-1:0] pc_addr_i,
  output logic [MemBusWidth-1:0]     pc_data_o,
  output logic                       err_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int IdxW    = $clog2(DEPTH);
  localparam int TagLsb  = IdxW + 2;
  localparam int WaitEff = (WAIT_CYCLES > RibRespWaitMax) ? RibRespWaitMax : WAIT_CYCLES;
  localparam logic [3:0] CntLoad = (WaitEff > 0) ? 4'(WaitEff - 1) : 4'd0;

  rib_resp_state_e state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  mem_addr_bus_t   lat_addr;
  logic            lat_we;
  mem_bus_t        lat_data;
  logic            lat_load;

  logic            hold;
  logic            cmpl;
  mem_addr_bus_t   cmpl_addr;
  logic            cmpl_we;
  mem_bus_t        cmpl_data;

  logic            cmpl_v;
  logic            cmpl_in_range;
  logic            pc_in_range;
  logic            mem_we;
  mem_bus_t        rd_data;
  mem_bus_t        pc_rd_data;
  logic            unused_addr_lsbs;

  // Next state, countdown and the access that completes this cycle (if any).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lat_load  = 1'b0;
    hold      = 1'b0;
    cmpl      = 1'b0;
    cmpl_addr = addr_i;
    cmpl_we   = we_i;
    cmpl_data = data_i;
    case (state)
      RibRespIdle: begin
        if (req_i) begin
          if (WaitEff == 0) begin
            cmpl = 1'b1;
          end else begin
            hold      = 1'b1;
            lat_load  = 1'b1;
            cnt_nxt   = CntLoad;
            state_nxt = RibRespWait;
          end
        end
      end
      RibRespWait: begin
        hold = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = RibRespDone;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RibRespDone: begin
        cmpl      = 1'b1;
        cmpl_addr = lat_addr;
        cmpl_we   = lat_we;
        cmpl_data = lat_data;
        state_nxt = RibRespIdle;
      end
      default: begin
        state_nxt = RibRespIdle;
      end
    endcase
  end

  // State, countdown and request latches; reset drops any pending access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RibRespIdle;
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_we   <= 1'b0;
      lat_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (lat_load) begin
        lat_addr <= addr_i;
        lat_we   <= we_i;
        lat_data <= data_i;
      end
    end
  end

  // Gate with reset so hold, data and writes are quiet while reset is held.
  assign hold_o        = hold & rst;
  assign cmpl_v        = cmpl & rst;
  assign cmpl_in_range = (cmpl_addr[MemAddrBusWidth-1:TagLsb] == BASE_ADDR[MemAddrBusWidth-1:TagLsb]);
  assign pc_in_range   = (pc_addr_i[MemAddrBusWidth-1:TagLsb] == BASE_ADDR[MemAddrBusWidth-1:TagLsb]);
  assign mem_we        = cmpl_v & cmpl_we & cmpl_in_range;
  assign data_o        = (cmpl_v & ~cmpl_we & cmpl_in_range) ? rd_data : '0;
  assign pc_data_o     = pc_in_range ? pc_rd_data : '0;

  // Byte offsets are meaningless for word-only accesses.
  assign unused_addr_lsbs = ^{cmpl_addr[1:0], pc_addr_i[1:0]};

  rib_resp_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (cmpl_addr[TagLsb-1:2]),
    .wdata   (cmpl_data),
    .rd_addr (cmpl_addr[TagLsb-1:2]),
    .rd_data (rd_data),
    .pc_addr (pc_addr_i[TagLsb-1:2]),
    .pc_data (pc_rd_data)
  );

`ifdef RIB_RESP_ERR_EN
  logic       err_pulse;
  logic [7:0] err_cnt;

  assign err_pulse = cmpl_v & ~cmpl_in_range;

  // Count out-of-range data accesses, sticking at the top value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 8'd0;
    end else if (err_pulse && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign err_o     = err_pulse;
  assign err_cnt_o = err_cnt;
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = 8'd0;
`endif

endmodule

// File: doc/rib_mem_responder.md
# rib_mem_responder

RIB bus responder (slave end) for the tinyriscv core's data port, plus a read-only instruction-fetch port onto the same storage. It answers the core's `rib_ex_*` requests with a configurable number of wait states, drives the bus hold flag so the pipeline stalls until the access completes, and returns fetch words combinationally. It sits between the core top and the SQED harness/SoC as the backing memory for load/store and fetch traffic.

## Interface
Parameters:
- `DEPTH`, 4096: number of 32-bit words; power of two.
- `WAIT_CYCLES`, 2: wait states per data access; legal range 0..15.
- `BASE_ADDR`, 32'h1000_0000: byte base of the decoded region; aligned to `DEPTH*4`.

Ports:
- `clk`, input, 1: the single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `req_i`, input, 1: data access request (core `rib_ex_req_o`).
- `we_i`, input, 1: write enable (core `rib_ex_we_o`).
- `addr_i`, input, 32: byte address (core `rib_ex_addr_o`).
- `data_i`, input, 32: write data (core `rib_ex_data_o`).
- `data_o`, output, 32: read data (to core `rib_ex_data_i`).
- `hold_o`, output, 1: bus hold (to core `rib_hold_flag_i`).
- `pc_addr_i`, input, 32: fetch byte address (core `rib_pc_addr_o`).
- `pc_data_o`, output, 32: fetch word (to core `rib_pc_data_i`).
- `err_o`, output, 1: out-of-range access pulse (present only with `RIB_RESP_ERR_EN`).
- `err_cnt_o`, output, 8: saturating error count (present only with `RIB_RESP_ERR_EN`).

## Operation
- Word access only. Word index = `addr[log2(DEPTH)+1:2]`; `addr[1:0]` ignored. Sub-word stores arrive as read-modify-write from the core.
- In range = `addr[31:log2(DEPTH)+2] == BASE_ADDR[31:log2(DEPTH)+2]`. An out-of-range read returns 0; an out-of-range write is dropped.
- FSM states: IDLE, WAIT, DONE.
  - IDLE with `req_i`=0: `hold_o`=0.
  - IDLE with `req_i`=1 and `WAIT_CYCLES`=0: the access completes in this cycle. `data_o` = mem[idx] combinationally, and a write commits at this edge. The FSM stays in IDLE.
  - IDLE with `req_i`=1 and `WAIT_CYCLES`>0: `hold_o`=1 combinationally. Latch addr/we/data, load cnt=`WAIT_CYCLES`-1, go to WAIT.
  - WAIT: `hold_o`=1. When cnt==0 go to DONE; otherwise decrement cnt. `req_i` is ignored.
  - DONE: `hold_o`=0. `data_o` = mem[latched idx]. A latched write commits at this edge. Go to IDLE unconditionally. `req_i` seen in DONE belongs to the completing access and never starts a new one.
- `data_o` = 0 whenever no read is completing.
- Fetch port: `pc_data_o` = mem[`pc_addr_i` idx], combinational and independent of the FSM. It returns 0 when out of range. A same-cycle write to the fetched word returns the old data.

## Timing
- Reset values: state IDLE, cnt 0, latches 0, `hold_o` 0, `data_o` 0, `err_o` 0, `err_cnt_o` 0. Memory contents are not reset.
- Data latency: `WAIT_CYCLES`+1 cycles from the request cycle to the DONE cycle. The core sees exactly `WAIT_CYCLES`+1 cycles of `hold_o`=1.
- Back-to-back requests: a new request is accepted in the cycle after DONE (IDLE).
- Reset asserted mid-access: return to IDLE immediately and deassert `hold_o`. A pending write is discarded.
- Fetch latency: 0 cycles (combinational).

## Configuration
- `RIB_RESP_ERR_EN` defined:
  - `err_o` pulses for one cycle at access completion (IDLE for 0 wait states, DONE otherwise) when the address is out of range.
  - `err_cnt_o` increments on each pulse and saturates at 255.
  - Fetch misses are not counted.
- `RIB_RESP_ERR_EN` undefined: `err_o` and `err_cnt_o` are tied to 0, and no counter logic is built.

## Structure
- Use `MemBus` and `MemAddrBus` from `defines.v`.
- Add to the shared package: `RibRespIdle`, `RibRespWait`, `RibRespDone` state encodings (2 bits) and `RibRespWaitMax` = 15.
- One sub-module, `rib_resp_mem`:
  - 1 write port and 2 asynchronous read ports (data and fetch).
  - Parameter `DEPTH`.
- The FSM, decode and error logic live in the top.

## Test plan
- `WAIT_CYCLES`=2: write 32'hDEAD_BEEF to 0x1000_0010.
  - `hold_o` is high for 3 cycles, and the write commits at the DONE edge.
  - A following read returns 32'hDEAD_BEEF in its DONE cycle.
- `WAIT_CYCLES`=0: read 0x1000_0010 after the write above.
  - `hold_o` stays 0.
  - `data_o` = 32'hDEAD_BEEF in the same cycle.
- Fetch at `pc_addr_i`=0x1000_0010 while a data write to 0x1000_0014 is held.
  - `pc_data_o` = 32'hDEAD_BEEF throughout.
  - The 0x14 word changes only after DONE.
- With `RIB_RESP_ERR_EN`, read 0x2000_0000:
  - `data_o` = 0 and `err_o` pulses once.
  - `err_cnt_o` goes 0→1.
  - 300 further misses saturate `err_cnt_o` at 255.
- Assert `rst` low during WAIT of a write to 0x1000_0020 holding 32'h1234_5678:
  - `hold_o` drops immediately.
  - A post-reset read of 0x1000_0020 does not return 32'h1234_5678 (preload the word with 0 first).
- `req_i` held high through DONE with an unchanged address: exactly one access and one hold window occur, then a second access starts in the next cycle.
